move_cmd_queue: RTL and testbench

Sits directly upstream of the character controller, between the five debounced push-button outputs and the movement/bomb-drop logic. Converts button press edges, sampled on the system clock, into discrete command tokens. Buffers them in a small FIFO and releases at most one command per character-movement tick. Presses shorter than a movement period are therefore never lost, and one held press never yields more than one command.

---
 rtl/move_cmd_queue_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/move_cmd_queue.sv | 142 ++++++++++++++
 tb/tb_move_cmd_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/move_cmd_queue_pkg.sv
// Command encoding shared by the button command queue and the character controller.
package move_cmd_queue_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_BOMB  = 3'd5
  } cmd_t;

  localparam int unsigned CMD_W = 3;

  // Button vector bit positions: {center, right, left, down, up}.
  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits, head visible combinationally.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;

endmodule

// File: rtl/move_cmd_queue.sv
// Turns button press edges into queued movement commands, released one per tick.
// Optional auto-repeat of a held direction is enabled by defining AUTO_REPEAT_EN.
module move_cmd_queue
  import move_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned REPEAT_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_center,
  input  logic             tick,
  output logic [2:0]       cmd_out,
  output logic             cmd_strobe,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  if (CNT_W != $clog2(DEPTH + 1) || REPEAT_TICKS < 1) begin : g_bad_params
    $error("move_cmd_queue: inconsistent CNT_W/DEPTH or REPEAT_TICKS < 1");
  end

  logic [4:0]       btn, btn_q, rise;
  cmd_t             sel_cmd, push_cmd, rpt_cmd, head_cmd;
  cmd_t             cmd_out_q, cmd_out_d;
  logic             strobe_q, strobe_d;
  logic             overflow_q, overflow_d;
  logic             push, rpt_push;
  logic [CMD_W-1:0] head;
  logic             fifo_full, fifo_empty;

  assign btn  = {btn_center, btn_right, btn_left, btn_down, btn_up};
  assign rise = btn & ~btn_q;

  // Only the highest-priority rise of a cycle becomes a command.
  always_comb begin
    sel_cmd = CMD_NONE;
    if      (rise[BTN_CENTER]) sel_cmd = CMD_BOMB;
    else if (rise[BTN_UP])     sel_cmd = CMD_UP;
    else if (rise[BTN_DOWN])   sel_cmd = CMD_DOWN;
    else if (rise[BTN_LEFT])   sel_cmd = CMD_LEFT;
    else if (rise[BTN_RIGHT])  sel_cmd = CMD_RIGHT;
  end

  assign push     = (sel_cmd != CMD_NONE) | rpt_push;
  assign push_cmd = (sel_cmd != CMD_NONE) ? sel_cmd : rpt_cmd;
  assign head_cmd = cmd_t'(head);

  cmd_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_cmd),
    .pop_i   (tick),
    .head_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    cmd_out_d  = cmd_out_q;
    strobe_d   = 1'b0;
    overflow_d = overflow_q | (push & fifo_full & ~tick);
    if (tick) begin
      cmd_out_d = fifo_empty ? CMD_NONE : head_cmd;
      strobe_d  = ~fifo_empty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q      <= '0;
      cmd_out_q  <= CMD_NONE;
      strobe_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      btn_q      <= btn;
      cmd_out_q  <= cmd_out_d;
      strobe_q   <= strobe_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_TICKS + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  cmd_t             last_cmd_q, last_cmd_d;
  logic             rpt_cond;

  // Repeat only the single held direction that was the last command emitted.
  always_comb begin
    rpt_cmd = CMD_NONE;
    case (btn[3:0])
      4'b0001: rpt_cmd = CMD_UP;
      4'b0010: rpt_cmd = CMD_DOWN;
      4'b0100: rpt_cmd = CMD_LEFT;
      4'b1000: rpt_cmd = CMD_RIGHT;
      default: rpt_cmd = CMD_NONE;
    endcase
    rpt_cond   = (rpt_cmd != CMD_NONE) && (rise == '0) && fifo_empty &&
                 (last_cmd_q == rpt_cmd);
    rpt_push   = 1'b0;
    rpt_cnt_d  = rpt_cnt_q;
    last_cmd_d = strobe_d ? cmd_out_d : last_cmd_q;
    if (!rpt_cond) begin
      rpt_cnt_d = '0;
    end else if (tick) begin
      if (rpt_cnt_q == RPT_W'(REPEAT_TICKS - 1)) begin
        rpt_push  = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q  <= '0;
      last_cmd_q <= CMD_NONE;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      last_cmd_q <= last_cmd_d;
    end
  end
`else
  assign rpt_push = 1'b0;
  assign rpt_cmd  = CMD_NONE;
`endif

  assign cmd_out    = cmd_out_q;
  assign cmd_strobe = strobe_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_move_cmd_queue.sv
// Randomized and directed bench for move_cmd_queue against a queue-based reference model.
module tb_move_cmd_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int RPT   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       btn_v = '0;  // {center, right, left, down, up}
  logic             tick = 1'b0;
  logic [2:0]       cmd_out;
  logic             cmd_strobe;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] exp_q[$];
  logic [2:0] exp_cmd;
  logic       exp_strobe;
  logic       exp_ovf;
  logic [4:0] m_prev;
  logic [2:0] m_last;
  int         m_cnt;

  move_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .REPEAT_TICKS(RPT)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_v[0]),
    .btn_down   (btn_v[1]),
    .btn_left   (btn_v[2]),
    .btn_right  (btn_v[3]),
    .btn_center (btn_v[4]),
    .tick       (tick),
    .cmd_out    (cmd_out),
    .cmd_strobe (cmd_strobe),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cmd    = 3'd0;
    exp_strobe = 1'b0;
    exp_ovf    = 1'b0;
    m_prev     = '0;
    m_last     = 3'd0;
    m_cnt      = 0;
  endtask

  function automatic logic [2:0] pick(input logic [4:0] r);
    if (r[4]) return 3'd5;
    if (r[0]) return 3'd1;
    if (r[1]) return 3'd2;
    if (r[2]) return 3'd3;
    if (r[3]) return 3'd4;
    return 3'd0;
  endfunction

  task automatic model_step(input logic [4:0] b, input logic t);
    logic [4:0] rise;
    logic [2:0] sel, dir, v;
    logic       rp;
    int         pre;
    rise = b & ~m_prev;
    sel  = pick(rise);
    pre  = exp_q.size();
    rp   = 1'b0;
    dir  = 3'd0;
`ifdef AUTO_REPEAT_EN
    if ($countones(b[3:0]) == 1) dir = pick({1'b0, b[3:0]});
    if (dir != 0 && rise == 0 && pre == 0 && m_last == dir) begin
      if (t) begin
        if (m_cnt == RPT - 1) begin rp = 1'b1; m_cnt = 0; end
        else m_cnt++;
      end
    end else begin
      m_cnt = 0;
    end
`endif
    exp_strobe = 1'b0;
    if (t) begin
      if (pre > 0) begin
        exp_cmd    = exp_q.pop_front();
        exp_strobe = 1'b1;
        m_last     = exp_cmd;
      end else begin
        exp_cmd = 3'd0;
      end
    end
    if (sel != 0 || rp) begin
      v = (sel != 0) ? sel : dir;
      if (pre < DEPTH || t) exp_q.push_back(v);
      else exp_ovf = 1'b1;
    end
    m_prev = b;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".cmd_out"}, cmd_out, exp_cmd);
    check_eq({where, ".strobe"}, cmd_strobe, exp_strobe);
    check_eq({where, ".count"}, count, exp_q.size());
    check_eq({where, ".overflow"}, overflow, exp_ovf);
  endtask

  task automatic cycle(input logic [4:0] b, input logic t);
    @(negedge clk);
    btn_v = b;
    tick  = t;
    @(posedge clk);
    model_step(b, t);
    #1;
    check_outputs("cyc");
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    rst   = 1'b0;
    btn_v = '0;
    tick  = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single held press, then three ticks
    repeat (5) cycle(5'b00001, 1'b0);
    cycle(5'b00000, 1'b0);
    check_eq("single.count", count, 1);
    repeat (3) begin cycle(5'b00000, 1'b1); cycle(5'b00000, 1'b0); end

    // Simultaneous left + center rises -> only bomb
    cycle(5'b10100, 1'b0);
    cycle(5'b00000, 1'b0);
    check_eq("simul.count", count, 1);
    cycle(5'b00000, 1'b1);
    check_eq("simul.cmd", cmd_out, 5);

    // Overflow with five presses, no ticks
    async_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(5'b00001 << i, 1'b0);
      cycle(5'b00000, 1'b0);
    end
    check_eq("ovf.count", count, DEPTH);
    check_eq("ovf.flag", overflow, 1);
    repeat (6) cycle(5'b00000, 1'b1);

    // Full FIFO with a rise coinciding with a tick
    async_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(5'b00001 << i, 1'b0);
      cycle(5'b00000, 1'b0);
    end
    cycle(5'b10000, 1'b1);
    check_eq("fullpop.count", count, DEPTH);
    check_eq("fullpop.ovf", overflow, 0);
    repeat (5) cycle(5'b00000, 1'b1);

    // Mid-stream reset with two entries queued
    cycle(5'b00001, 1'b0);
    cycle(5'b00000, 1'b0);
    cycle(5'b00010, 1'b0);
    cycle(5'b00000, 1'b0);
    async_reset();
    repeat (2) cycle(5'b00000, 1'b1);

    // Held right across many ticks (repeats only when the feature is built in)
    for (int i = 0; i < 14; i++) cycle(5'b01000, (i % 2) == 1);
    repeat (4) cycle(5'b00000, 1'b1);

    // Random stimulus
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] b;
      b = btn_v;
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 7) == 0) b[k] = ~b[k];
      if ($urandom_range(0, 599) == 0) async_reset();
      else cycle(b, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
